// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud
    localparam int DEFAULT_SYNC_STAGES  = 2;

    // PARITY is only entered when UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter used as the bit-timing reference for the UART.
// It counts down to zero and then holds; o_expired is high while the
// count is zero. The owner reloads it on every expiry, so it never wraps.
module uart_baud_cnt #(
    parameter int WIDTH = 14
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority over counting; the counter parks at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle high.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit, parity_err output).
//
// Output handshake: data/data_valid form a one-entry holding register.
// A transfer happens on a rising clk edge where data_valid & data_ready
// are both high; data is stable while data_valid is high. A byte that
// completes while the register is full and not being accepted is dropped
// and overrun pulses for one cycle.
//
// dbg_state exposes the FSM state for observation only.
import uart_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    // First sample lands mid start bit; later samples one bit apart.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    // Shift the asynchronous line through SYNC_STAGES flops; idle is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Baud counter
    // ------------------------------------------------------------------
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_expired;

    uart_baud_cnt #(
        .WIDTH (CNT_W)
    ) u_baud_cnt (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .o_expired  (w_cnt_expired)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    uart_state_t          r_state;
    uart_state_t          w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 w_clr_idx;
    logic                 w_sample_bit;
    logic                 w_byte_done;
    logic                 w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 w_par_sample;
    logic                 w_parity_err;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decisions, all from rx_s.
    always_comb begin
        w_next_state   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = FULL_LOAD;
        w_clr_idx      = 1'b0;
        w_sample_bit   = 1'b0;
        w_byte_done    = 1'b0;
        w_frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample   = 1'b0;
        w_parity_err   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = HALF_LOAD;
                    w_next_state   = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_expired) begin
                    if (!w_rx_s) begin
                        w_cnt_load   = 1'b1;
                        w_clr_idx    = 1'b1;
                        w_next_state = ST_DATA;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_cnt_expired) begin
                    w_sample_bit = 1'b1;
                    w_cnt_load   = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_next_state = ST_PARITY;
`else
                        w_next_state = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_cnt_expired) begin
                    w_par_sample = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_next_state = ST_STOP;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (w_cnt_expired) begin
                    // Leave mid stop bit so a following start edge is not missed.
                    w_next_state = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    w_parity_err = r_par_bad;
                    w_frame_err  = !w_rx_s;
                    w_byte_done  = w_rx_s && !r_par_bad;
`else
                    w_frame_err  = !w_rx_s;
                    w_byte_done  = w_rx_s;
`endif
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Assemble the byte LSB first; bit index restarts at each start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_clr_idx) begin
            r_bit_idx <= '0;
        end else if (w_sample_bit) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must have an even count of ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bad <= 1'b0;
        end else if (w_clr_idx) begin
            r_par_bad <= 1'b0;
        end else if (w_par_sample) begin
            r_par_bad <= (^r_shift) ^ w_rx_s;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Holding register and status pulses
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_data;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_err;
`endif

    // Deliver completed bytes, honour accepts, and raise one-cycle flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
            if (w_byte_done) begin
                if (!r_data_valid || data_ready) begin
                    // Free, or being emptied this same edge: take the new byte.
                    r_data       <= r_shift;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule
